// File: rtl/move_command_tx.sv
// IR transmitter for the rover move-command link: latches a 12-bit command and sends it
// as a pulse-width-coded, carrier-modulated frame (start mark + 12 bits LSB first), REPEATS times.
module move_command_tx #(
  parameter int CLOCK_HZ    = 27000000,
  parameter int CARRIER_HZ  = 40000,
  parameter int UNIT_US     = 600,
  parameter int FRAME_UNITS = 75,
  parameter int REPEATS     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] move_command,
  output logic        busy,
  output logic        done,
  output logic        envelope,
  output logic        ir_out
);

  localparam int HALF_CYC  = CLOCK_HZ / (2 * CARRIER_HZ);
  localparam int UNIT_CYC  = (CLOCK_HZ / 1000000) * UNIT_US;
  localparam int START_CYC = 4 * UNIT_CYC;
  localparam int FRAME_CYC = FRAME_UNITS * UNIT_CYC;
  localparam int UNIT_W    = $clog2(START_CYC + 1);
  localparam int FRAME_W   = $clog2(FRAME_CYC + 1);
  localparam int PHASE_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  localparam logic [UNIT_W-1:0]  START_LAST = UNIT_W'(START_CYC - 1);
  localparam logic [UNIT_W-1:0]  UNIT_LAST  = UNIT_W'(UNIT_CYC - 1);
  localparam logic [UNIT_W-1:0]  MARK1_LAST = UNIT_W'(2 * UNIT_CYC - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYC - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF_CYC - 1);
  localparam logic [2:0]         REP_INIT   = 3'(REPEATS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT_SPACE,
    BIT_MARK,
    GAP,
    DONE
  } state_t;

  state_t               state, state_next;
  logic [UNIT_W-1:0]    unit_cnt;
  logic [FRAME_W-1:0]   frame_cnt;
  logic [PHASE_W-1:0]   phase_cnt, phase_d;
  logic                 carrier, carrier_d;
  logic [11:0]          shreg, word_latched;
  logic [3:0]           bit_cnt;
  logic [2:0]           rpt_cnt;

  logic accept, unit_end, last_bit, frame_end, last_rep;
  logic mark_next, mark_entry, timed_state;

  assign accept    = ((state == IDLE) || (state == DONE)) && enable;
  assign last_bit  = (bit_cnt == 4'd11);
  assign frame_end = (frame_cnt == FRAME_LAST);
  assign last_rep  = (rpt_cnt == 3'd1);
  assign timed_state = (state == START) || (state == BIT_SPACE) || (state == BIT_MARK);

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    unit_end = 1'b0;
    case (state)
      START:     unit_end = (unit_cnt == START_LAST);
      BIT_SPACE: unit_end = (unit_cnt == UNIT_LAST);
      BIT_MARK:  unit_end = (unit_cnt == (shreg[0] ? MARK1_LAST : UNIT_LAST));
      default:   unit_end = 1'b0;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable) state_next = START;
      START:     if (unit_end) state_next = BIT_SPACE;
      BIT_SPACE: if (unit_end) state_next = BIT_MARK;
      BIT_MARK:  if (unit_end) state_next = last_bit ? GAP : BIT_SPACE;
      GAP:       if (frame_end) state_next = last_rep ? DONE : START;
      DONE:      state_next = enable ? START : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the carrier phase.
  always_comb begin
    mark_next  = (state_next == START) || (state_next == BIT_MARK);
    mark_entry = mark_next && (state_next != state);
    phase_d    = phase_cnt;
    carrier_d  = carrier;
    if (mark_entry) begin
      phase_d   = '0;
      carrier_d = 1'b1;
    end else if (mark_next) begin
      if (phase_cnt == PHASE_LAST) begin
        phase_d   = '0;
        carrier_d = ~carrier;
      end else begin
        phase_d = phase_cnt + 1'b1;
      end
    end
  end

  // NOTE: the shift register and latched word are plain flops, so they are reset like the rest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      envelope     <= 1'b0;
      ir_out       <= 1'b0;
      phase_cnt    <= '0;
      carrier      <= 1'b0;
      unit_cnt     <= '0;
      frame_cnt    <= '0;
      shreg        <= '0;
      word_latched <= '0;
      bit_cnt      <= '0;
      rpt_cnt      <= '0;
    end else begin
      busy      <= (state_next == START) || (state_next == BIT_SPACE) ||
                   (state_next == BIT_MARK) || (state_next == GAP);
      done      <= (state_next == DONE);
      envelope  <= mark_next;
      ir_out    <= mark_next & carrier_d;
      phase_cnt <= phase_d;
      carrier   <= carrier_d;

      // Unit counter only runs in the timed states, so it can never wrap in the long gap.
      if (!timed_state || (state_next != state)) unit_cnt <= '0;
      else                                       unit_cnt <= unit_cnt + 1'b1;

      if ((state_next == START) && (state != START)) frame_cnt <= '0;
      else if (timed_state || (state == GAP))        frame_cnt <= frame_cnt + 1'b1;

      if (accept) begin
        shreg        <= move_command;
        word_latched <= move_command;
        rpt_cnt      <= REP_INIT;
        bit_cnt      <= '0;
      end else if ((state == BIT_MARK) && unit_end) begin
        shreg   <= shreg >> 1;
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end else if ((state == GAP) && frame_end) begin
        rpt_cnt <= rpt_cnt - 3'd1;
        shreg   <= word_latched;
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_move_command_tx.sv
// Self-checking bench for move_command_tx: decodes the IR frames from envelope/ir_out and
// compares them against a scoreboard of words pushed when each command is issued.
module tb_move_command_tx;

  localparam int UNIT  = 10;
  localparam int HALF  = 5;
  localparam int FRAME = 750;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_a = 1'b0, enable_b = 1'b0;
  logic [11:0] cmd_a = '0, cmd_b = '0;
  logic        busy_a, done_a, env_a, ir_a;
  logic        busy_b, done_b, env_b, ir_b;

  move_command_tx #(
    .CLOCK_HZ(1000000), .CARRIER_HZ(100000), .UNIT_US(10), .FRAME_UNITS(75), .REPEATS(1)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(enable_a), .move_command(cmd_a),
    .busy(busy_a), .done(done_a), .envelope(env_a), .ir_out(ir_a)
  );

  move_command_tx #(
    .CLOCK_HZ(1000000), .CARRIER_HZ(100000), .UNIT_US(10), .FRAME_UNITS(75), .REPEATS(3)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b), .move_command(cmd_b),
    .busy(busy_b), .done(done_b), .envelope(env_b), .ir_out(ir_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int done_cnt_a = 0, done_cnt_b = 0;
  always @(negedge clock) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  logic mon_sel = 1'b0;
  logic m_env, m_ir, m_busy, m_done;
  assign m_env  = mon_sel ? env_b  : env_a;
  assign m_ir   = mon_sel ? ir_b   : ir_a;
  assign m_busy = mon_sel ? busy_b : busy_a;
  assign m_done = mon_sel ? done_b : done_a;

  logic [11:0] sb_q[$];
  int n_checks = 0, n_pass = 0;
  int carrier_err;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Count consecutive samples at 'level', checking the carrier pattern along the way.
  task automatic run_len(input logic level, input int limit, output int width);
    width = 0;
    while ((m_env === level) && (width < limit)) begin
      if (level) begin
        if (m_ir !== (((width % (2 * HALF)) < HALF) ? 1'b1 : 1'b0)) carrier_err++;
      end else if (m_ir !== 1'b0) begin
        carrier_err++;
      end
      width++;
      @(negedge clock);
    end
  endtask

  // Entered on the first sample of a start mark; leaves on the done sample or the next start mark.
  task automatic rx_frame(input bit expect_done, output int body_len);
    int rise, w, off, space_bad, mark_bad, busy_bad;
    logic [11:0] word, exp_word;
    rise = cyc; word = '0; space_bad = 0; mark_bad = 0; busy_bad = 0; carrier_err = 0;
    run_len(1'b1, 100, w);
    check("start_mark_width", w, 4 * UNIT);
    for (int b = 0; b < 12; b++) begin
      run_len(1'b0, 100, w);
      if (w != UNIT) space_bad++;
      run_len(1'b1, 100, w);
      if (w == 2 * UNIT) word[b] = 1'b1;
      else if (w != UNIT) mark_bad++;
    end
    body_len = cyc - rise;
    off = 0;
    while ((m_done !== 1'b1) && (m_env !== 1'b1) && (off < 2000)) begin
      if (m_ir !== 1'b0) carrier_err++;
      if (m_busy !== 1'b1) busy_bad++;
      @(negedge clock);
      off++;
    end
    check("space_width_errors", space_bad, 0);
    check("mark_width_errors", mark_bad, 0);
    check("carrier_errors", carrier_err, 0);
    check("busy_drop_in_frame", busy_bad, 0);
    check("frame_period", cyc - rise, FRAME);
    check("done_at_frame_end", m_done, expect_done);
    check("scoreboard_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      exp_word = sb_q.pop_front();
      check("decoded_word", word, exp_word);
    end
  endtask

  task automatic start_cmd(input bit sel, input logic [11:0] cmd, input int frames);
    @(negedge clock);
    mon_sel = sel;
    if (sel) begin cmd_b = cmd; enable_b = 1'b1; end
    else     begin cmd_a = cmd; enable_a = 1'b1; end
    check("busy_before_accept", m_busy, 0);
    for (int i = 0; i < frames; i++) sb_q.push_back(cmd);
    @(negedge clock);
    enable_a = 1'b0;
    enable_b = 1'b0;
    check("busy_after_accept", m_busy, 1);
    check("envelope_after_accept", m_env, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    int blen, d0, cnt;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_envelope", env_a, 0);
    check("reset_ir_out", ir_a, 0);
    check("reset_busy_b", busy_b, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 0x730 with an ignored second enable carrying 0x0AA mid-frame.
    start_cmd(1'b0, 12'h730, 1);
    d0 = done_cnt_a;
    fork
      rx_frame(1'b1, blen);
      begin
        repeat (100) @(negedge clock);
        cmd_a = 12'h0AA;
        enable_a = 1'b1;
        @(negedge clock);
        enable_a = 1'b0;
      end
    join
    check("body_len_730", blen, 330);
    @(negedge clock);
    check("done_one_cycle", m_done, 0);
    check("busy_after_done", m_busy, 0);
    check("done_count_730", done_cnt_a - d0, 1);
    cnt = 0;
    repeat (100) begin
      @(negedge clock);
      if (m_env !== 1'b0 || m_busy !== 1'b0) cnt++;
    end
    check("no_retrigger_from_ignored_enable", cnt, 0);

    // All-ones word: longest possible frame body.
    start_cmd(1'b0, 12'hFFF, 1);
    rx_frame(1'b1, blen);
    check("body_len_fff", blen, 400);
    @(negedge clock);

    // Three repeats on the second instance.
    start_cmd(1'b1, 12'h001, 3);
    d0 = done_cnt_b;
    rx_frame(1'b0, blen);
    rx_frame(1'b0, blen);
    rx_frame(1'b1, blen);
    @(negedge clock);
    check("done_one_cycle_rep", m_done, 0);
    check("done_count_rep", done_cnt_b - d0, 1);

    // Asynchronous reset in the middle of the first bit mark.
    start_cmd(1'b0, 12'h5A5, 0);
    repeat (52) @(negedge clock);
    check("pre_reset_envelope", env_a, 1);
    check("pre_reset_ir_out", ir_a, 1);
    d0 = done_cnt_a;
    #1 reset = 1'b0;
    #1;
    check("async_reset_envelope", env_a, 0);
    check("async_reset_ir_out", ir_a, 0);
    check("async_reset_busy", busy_a, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_idle_busy", busy_a, 0);
    check("post_reset_idle_env", env_a, 0);
    check("no_done_after_abort", done_cnt_a - d0, 0);
    start_cmd(1'b0, 12'h5A5, 1);
    rx_frame(1'b1, blen);
    @(negedge clock);
    check("done_count_fresh", done_cnt_a - d0, 1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
